// File: rtl/uio_bus_arbiter_if.sv
// Requester/pin-side bundle for uio_bus_arbiter. The arbiter uses the slave modport.
// The requester raises req and holds it until its burst ends; gnt is the registered answer.
// A beat is any cycle with gnt & req & ena; last marks the final beat; uio_oe/uio_out drive the pins.
interface uio_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                 ena;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   dir;
  logic [NUM_REQ*8-1:0] wdata;
  logic [NUM_REQ-1:0]   last;
  logic [NUM_REQ-1:0]   gnt;
  logic [7:0]           uio_in;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;
  logic [7:0]           rdata;
  logic                 rvalid;
  logic                 busy;

  modport slave (
    input  ena, req, dir, wdata, last, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid, busy
  );

  modport master (
    output ena, req, dir, wdata, last, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pin bank between NUM_REQ requesters,
// with a released-bus turnaround before every grant and bounded burst length.
module uio_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  uio_bus_arbiter_if.slave  bus,
  output logic [1:0]        state_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, OWN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               odir_q, odir_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [3:0]         turn_q, turn_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         oe_q, oe_d;
  logic [7:0]         out_q, out_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic [IW-1:0]      win;
  logic               win_vld;
  logic [IW-1:0]      next_ptr;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    logic end_burst;
    end_burst = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    odir_d    = odir_q;
    ptr_d     = ptr_q;
    turn_d    = turn_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    oe_d      = oe_q;
    out_d     = out_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ena && win_vld) begin
          owner_d = win;
          odir_d  = bus.dir[win];
          turn_d  = 4'(TURN_CYCLES);
          state_d = TURN;
        end
      end
      TURN: begin
        gnt_d = '0;
        oe_d  = '0;
        out_d = '0;
        if (!bus.req[owner_q] || !bus.ena) begin
          state_d = IDLE;
        end else if (turn_q <= 4'd1) begin
          // Counter reaches zero on this edge; the write owner's data is preloaded so the pins are valid in the first grant cycle.
          state_d        = OWN;
          turn_d         = '0;
          gnt_d[owner_q] = 1'b1;
          if (odir_q) begin
            oe_d  = 8'hFF;
            out_d = bus.wdata[{owner_q, 3'b000} +: 8];
          end
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      OWN: begin
        if (!bus.req[owner_q] || !bus.ena) begin
          end_burst = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (odir_q) begin
            out_d = bus.wdata[{owner_q, 3'b000} +: 8];
          end else begin
            rdata_d  = bus.uio_in;
            rvalid_d = 1'b1;
          end
          if (bus.last[owner_q] || (cnt_q + 8'd1) == 8'(MAX_BURST)) begin
            end_burst = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (end_burst) begin
      gnt_d   = '0;
      oe_d    = '0;
      out_d   = '0;
      cnt_d   = '0;
      ptr_d   = next_ptr;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      odir_q   <= 1'b0;
      ptr_q    <= '0;
      turn_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      oe_q     <= '0;
      out_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      odir_q   <= odir_d;
      ptr_q    <= ptr_d;
      turn_q   <= turn_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.uio_oe  = oe_q;
  assign bus.uio_out = out_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.busy    = (state_q != IDLE);
  assign state_o     = state_q;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios plus randomized traffic against a
// behavioural model; grant order is also tracked through an expected-owner queue.
module tb_uio_bus_arbiter;
  localparam int N  = 4;
  localparam int MB = 8;
  localparam int TC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_o;

  uio_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  uio_bus_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TURN_CYCLES(TC)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];

  // Behavioural model: phase 0 idle, 1 waiting out the turnaround, 2 owning the bus.
  int         m_phase = 0;
  int         m_wait  = 0;
  int         m_owner = 0;
  int         m_beats = 0;
  int         m_ptr   = 0;
  bit         m_dir   = 1'b0;
  logic [N-1:0] e_gnt   = '0;
  logic [7:0]   e_oe    = '0;
  logic [7:0]   e_out   = '0;
  logic [7:0]   e_rdata = '0;
  logic         e_rvalid = 1'b0;
  logic         e_busy   = 1'b0;

  always @(posedge clk) begin
    bit fin;
    fin = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_beats = 0;
      e_gnt = '0; e_oe = '0; e_out = '0; e_rdata = '0; e_rvalid = 1'b0;
    end else begin
      e_rvalid = 1'b0;
      case (m_phase)
        0: if (bus.ena && bus.req != '0) begin
          for (int k = 0; k < N; k++) begin
            if (bus.req[(m_ptr + k) % N]) begin
              m_owner = (m_ptr + k) % N;
              break;
            end
          end
          m_dir   = bus.dir[m_owner];
          m_wait  = TC;
          m_phase = 1;
        end
        1: if (!bus.req[m_owner] || !bus.ena) begin
          m_phase = 0;
        end else begin
          m_wait = m_wait - 1;
          if (m_wait == 0) begin
            m_phase = 2;
            m_beats = 0;
            e_gnt = '0;
            e_gnt[m_owner] = 1'b1;
            e_oe  = m_dir ? 8'hFF : 8'h00;
            e_out = m_dir ? bus.wdata[8*m_owner +: 8] : 8'h00;
            exp_q.push_back(2'(m_owner));
          end
        end
        default: if (!bus.req[m_owner] || !bus.ena) begin
          fin = 1'b1;
        end else begin
          m_beats = m_beats + 1;
          if (m_dir) e_out = bus.wdata[8*m_owner +: 8];
          else begin
            e_rdata  = bus.uio_in;
            e_rvalid = 1'b1;
          end
          if (bus.last[m_owner] || m_beats == MB) fin = 1'b1;
        end
      endcase
      if (fin) begin
        e_gnt = '0; e_oe = '0; e_out = '0;
        m_ptr   = (m_owner + 1) % N;
        m_phase = 0;
      end
    end
    e_busy = (m_phase != 0);
  end

  // Grant-order scoreboard and bus-safety invariants, sampled on the falling edge.
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    logic [1:0] w;
    if (bus.gnt != '0 && prev_gnt == '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_order: got gnt=%b, required no grant", bus.gnt);
      end else begin
        w = exp_q.pop_front();
        if (bus.gnt !== (4'b0001 << w)) begin
          n_fail++;
          $display("FAIL grant_order: got gnt=%b, required owner %0d", bus.gnt, w);
        end
      end
    end
    n_checks++;
    if (!(bus.gnt == '0 || $onehot(bus.gnt)) || !(bus.uio_oe == 8'h00 || bus.uio_oe == 8'hFF) ||
        (bus.uio_oe != 8'h00 && bus.gnt == '0)) begin
      n_fail++;
      $display("FAIL invariant: got gnt=%b uio_oe=%h, required one-hot-or-zero gnt and oe only under grant",
               bus.gnt, bus.uio_oe);
    end
    prev_gnt = bus.gnt;
  end

  task automatic idle_inputs();
    bus.ena = 1'b1; bus.req = '0; bus.dir = '0; bus.last = '0;
    bus.wdata = '0; bus.uio_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ena = 1'b1; bus.req = 4'b1111; bus.dir = 4'b1111; bus.last = '0;
    bus.wdata = $urandom; bus.uio_in = 8'h00;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== '0 || bus.uio_oe !== 8'h00 || bus.uio_out !== 8'h00 ||
          bus.rvalid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: got gnt=%b oe=%h out=%h rvalid=%b busy=%b, required all zero",
                 bus.gnt, bus.uio_oe, bus.uio_out, bus.rvalid, bus.busy);
      end
    end
    n_checks++;
    if (bus.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h, required 00", bus.rdata);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata = 32'h0000_00A5;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_turn: got gnt=%b busy=%b, required 0000 1", bus.gnt, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0001 || bus.uio_oe !== 8'hFF || bus.uio_out !== 8'hA5) begin
        n_fail++;
        $display("FAIL write_beat%0d: got gnt=%b oe=%h out=%h, required 0001 ff a5",
                 i, bus.gnt, bus.uio_oe, bus.uio_out);
      end
      if (i == 2) bus.last = 4'b0001;
    end
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== '0 || bus.uio_oe !== 8'h00 || bus.uio_out !== 8'h00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_end: got gnt=%b oe=%h out=%h busy=%b, required 0000 00 00 0",
               bus.gnt, bus.uio_oe, bus.uio_out, bus.busy);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    int m;
    do_reset();
    bus.req = 4'b1111; bus.dir = 4'b1111; bus.wdata = $urandom;
    // Grant starts two edges after the request, lasts MB cycles, then a two-cycle gap.
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      m = k - 2;
      exp_g = '0;
      if (m >= 0 && (m % 10) < MB) exp_g[(m / 10) % N] = 1'b1;
      n_checks++;
      if (bus.gnt !== exp_g) begin
        n_fail++;
        $display("FAIL round_robin cycle %0d: got gnt=%b, required %b", k, bus.gnt, exp_g);
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_read();
    do_reset();
    bus.req = 4'b0100; bus.dir = 4'b0000; bus.uio_in = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.uio_oe !== 8'h00 || bus.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant: got gnt=%b oe=%h rvalid=%b, required 0100 00 0",
               bus.gnt, bus.uio_oe, bus.rvalid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 8'h3C || bus.uio_oe !== 8'h00 ||
          bus.gnt !== ((i == 3) ? 4'b0000 : 4'b0100)) begin
        n_fail++;
        $display("FAIL read_beat%0d: got rvalid=%b rdata=%h oe=%h gnt=%b, required 1 3c 00 and grant until last",
                 i, bus.rvalid, bus.rdata, bus.uio_oe, bus.gnt);
      end
      if (i == 2) bus.last = 4'b0100;
      if (i == 3) begin
        bus.last = '0;
        bus.req  = 4'b1001;
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.rvalid !== 1'b0 || bus.gnt !== '0) begin
      n_fail++;
      $display("FAIL read_after: got rvalid=%b gnt=%b, required 0 0000", bus.rvalid, bus.gnt);
    end
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL read_next_owner: got gnt=%b, required 1000", bus.gnt);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_ena_drop();
    do_reset();
    bus.req = 4'b0001; bus.dir = 4'b0001; bus.wdata = 32'h0000_005A;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.uio_oe !== 8'hFF) begin
      n_fail++;
      $display("FAIL ena_grant: got gnt=%b oe=%h, required 0001 ff", bus.gnt, bus.uio_oe);
    end
    repeat (2) @(negedge clk);
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== '0 || bus.uio_oe !== 8'h00 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ena_drop%0d: got gnt=%b oe=%h busy=%b, required 0000 00 0",
                 i, bus.gnt, bus.uio_oe, bus.busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.req = 4'b0010; bus.dir = 4'b0011; bus.wdata = $urandom;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL withdraw_grant: got gnt=%b, required 0010", bus.gnt);
    end
    bus.req = 4'b0011;
    repeat (2) @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_end: got gnt=%b busy=%b, required 0000 0", bus.gnt, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== '0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL withdraw_turn: got gnt=%b busy=%b, required 0000 1", bus.gnt, bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.uio_oe !== 8'hFF) begin
      n_fail++;
      $display("FAIL withdraw_next: got gnt=%b oe=%h, required 0001 ff", bus.gnt, bus.uio_oe);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== e_gnt || bus.uio_oe !== e_oe || bus.uio_out !== e_out ||
          bus.rvalid !== e_rvalid || bus.busy !== e_busy || bus.rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL random cycle %0d: got gnt=%b oe=%h out=%h rv=%b busy=%b rd=%h, required %b %h %h %b %b %h",
                 c, bus.gnt, bus.uio_oe, bus.uio_out, bus.rvalid, bus.busy, bus.rdata,
                 e_gnt, e_oe, e_out, e_rvalid, e_busy, e_rdata);
      end
      rst = ($urandom_range(0, 199) == 0);
      bus.ena = ($urandom_range(0, 19) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
        bus.last[i] = ($urandom_range(0, 4) == 0);
      end
      bus.dir    = N'($urandom);
      bus.wdata  = $urandom;
      bus.uio_in = 8'($urandom);
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_ena_drop();
    test_withdraw();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL grant_queue: got %0d grants never issued, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
